digest_target_reader: RTL and testbench
=======================================

DIGEST_TARGET_READER -- requirements
Module: digest_target_reader

Interface
REQ-001 SHALL have parameter STREAM_EN, default 1: 1 streams the captured digest after comparison; 0 skips streaming.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port hash_valid  input  1  one-cycle pulse marking HASH and target valid.
REQ-005 SHALL have port HASH  input  256  digest {h0..h7}, with h0 in [255:224].
REQ-006 SHALL have port target  input  256  difficulty target, same word order as HASH.
REQ-007 SHALL have port nonce_in  input  32  nonce associated with HASH.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse when the comparison is decided.
REQ-010 SHALL have port hit  output  1  1 when the captured digest is strictly less than the captured target.
REQ-011 SHALL have port hit_nonce  output  32  captured nonce of the last hit.
REQ-012 SHALL have ports word_valid (output, 1), word_ready (input, 1), word (output, 32), word_index (output, 3) and word_last (output, 1), forming the digest stream.
REQ-013 SHALL have port drop_count  output  8  saturating count of ignored hash_valid pulses.

Function
REQ-014 FSM states SHALL be IDLE, COMPARE and STREAM.
REQ-015 In IDLE with hash_valid=1, the block SHALL capture HASH, target and nonce_in, clear the word counter and move to COMPARE.
REQ-016 COMPARE SHALL examine one 32-bit word per cycle, MSW first: word k in the k-th COMPARE cycle, k=0..7, using unsigned compare.
REQ-017 Compare outcome per word k: digest<target decides hit=1; digest>target decides hit=0; equal advances to k+1.
REQ-018 If all 8 words are equal, the result SHALL be hit=0 (strict less-than).
REQ-019 result_valid SHALL pulse in the cycle after the deciding word; hit SHALL update in that same cycle and hold until the next decision.
REQ-020 On hit=1, hit_nonce SHALL load the captured nonce in the result_valid cycle; otherwise hit_nonce SHALL hold its value.
REQ-021 Latency from the hash_valid cycle to result_valid SHALL be k+2 cycles, where k is the deciding word (2 minimum, 9 maximum).
REQ-022 With STREAM_EN=1, the block SHALL enter STREAM in the result_valid cycle, with word_valid=1, word=h0 and word_index=0.
REQ-023 With STREAM_EN=0, the block SHALL return to IDLE in the result_valid cycle.
REQ-024 A stream transfer SHALL occur on each cycle where word_valid=1 and word_ready=1; word_index SHALL then increment.
REQ-025 While word_valid=1 and word_ready=0, word, word_index and word_last SHALL hold stable.
REQ-026 word_last SHALL be 1 only when word_index=7.
REQ-027 The transfer of index 7 SHALL return the block to IDLE, with word_valid=0 in the next cycle.
REQ-028 hash_valid in COMPARE or STREAM SHALL be ignored and SHALL increment drop_count, saturating at 255.
REQ-029 hash_valid in the same cycle as the final transfer (return to IDLE) SHALL be dropped and counted, not captured.
REQ-030 word_ready SHALL be ignored when word_valid=0.

Reset
REQ-031 Asserting reset (low) at any time, including mid-COMPARE or mid-STREAM, SHALL immediately force IDLE.
REQ-032 Reset SHALL also force busy=0, result_valid=0, hit=0, hit_nonce=0, word_valid=0, word=0, word_index=0, word_last=0, drop_count=0 and clear the captured registers.
REQ-033 After reset is released, the first capture SHALL occur no earlier than the first rising clock edge with reset high.

Verification
REQ-034 Early decision: HASH MSW=0x00000000, target MSW=0x00000001, with the remaining words arbitrary -> result_valid at cycle +2, hit=1, hit_nonce=nonce_in.
REQ-035 Equal digest: HASH=target=0x1111...1111 -> result_valid at cycle +9, hit=0, hit_nonce unchanged.
REQ-036 Last-word decision: words 0..6 equal, word 7 of HASH=0x5 and word 7 of target=0x6 -> result_valid at cycle +9, hit=1.
REQ-037 Backpressure: word_ready toggling 1,0,0,1,... -> words h0..h7 delivered in order, each held while stalled, and word_last set on index 7 only.
REQ-038 Drops: three hash_valid pulses while busy -> drop_count=3; with 300 pulses -> drop_count=255.
REQ-039 Mid-stream reset: reset low at word_index=4 -> all outputs zero asynchronously; a new hash_valid after release is captured normally.

Source files
------------

// File: rtl/digest_target_reader.sv
// digest_target_reader
//   Captures a 256-bit digest, a 256-bit difficulty target and a nonce on a
//   hash_valid pulse. It then compares digest against target one 32-bit word
//   per cycle, most-significant word first, and reports whether
//   digest < target. With STREAM_EN=1 the captured digest is then sent out
//   as eight 32-bit words over a valid/ready stream.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   hash_valid           one-cycle capture strobe for HASH/target/nonce_in
//   HASH, target         {w0..w7}, w0 (MSW) in [255:224]
//   nonce_in             nonce tied to HASH
//   busy                 state != IDLE
//   result_valid         one-cycle pulse when the comparison is decided
//   hit, hit_nonce       decision (held), nonce of the last hit
//   word_*               digest stream (valid/ready, index, last)
//   drop_count           saturating count of hash_valid pulses ignored while busy
module digest_target_reader #(
    parameter bit STREAM_EN = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hash_valid,
    input  logic [255:0] HASH,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_in,
    output logic         busy,
    output logic         result_valid,
    output logic         hit,
    output logic [31:0]  hit_nonce,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [31:0]  word,
    output logic [2:0]   word_index,
    output logic         word_last,
    output logic [7:0]   drop_count
);

    typedef enum logic [1:0] {IDLE, COMPARE, STREAM} state_t;

    state_t state, state_nxt;

    // Packed as [7:0][31:0] so element 7 is the MSW; word k lives at [~k].
    logic [7:0][31:0] hash_q;
    logic [7:0][31:0] target_q;
    logic [31:0]      nonce_q;
    logic [2:0]       cnt;       // compare word k, then stream index

    logic [31:0] hash_w, target_w;
    logic        lt, gt, decide, xfer;

    assign hash_w   = hash_q[~cnt];
    assign target_w = target_q[~cnt];
    assign lt       = hash_w < target_w;
    assign gt       = hash_w > target_w;
    // Word 7 decides even when equal: all-equal means not strictly less.
    assign decide   = (state == COMPARE) && (lt || gt || (cnt == 3'd7));
    assign xfer     = (state == STREAM) && word_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hash_valid) state_nxt = COMPARE;
            COMPARE: if (decide)     state_nxt = STREAM_EN ? STREAM : IDLE;
            STREAM:  if (xfer && (cnt == 3'd7)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash_q       <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            cnt          <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            hit_nonce    <= '0;
            drop_count   <= '0;
        end else begin
            result_valid <= decide;
            if (state == IDLE && hash_valid) begin
                hash_q   <= HASH;
                target_q <= target;
                nonce_q  <= nonce_in;
                cnt      <= '0;
            end
            if (decide) begin
                hit <= lt;
                if (lt) hit_nonce <= nonce_q;
                cnt <= '0;                 // stream starts at h0
            end else if (state == COMPARE) begin
                cnt <= cnt + 3'd1;
            end
            // Index 7 wraps back to 0, leaving IDLE with a clean counter.
            if (xfer) cnt <= cnt + 3'd1;
            // Includes the cycle of the final transfer: still STREAM here.
            if (hash_valid && state != IDLE && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign busy       = (state != IDLE);
    assign word_valid = (state == STREAM);
    assign word_index = word_valid ? cnt : 3'd0;
    assign word       = word_valid ? hash_w : 32'd0;
    assign word_last  = word_valid && (cnt == 3'd7);

endmodule

// File: tb/tb_digest_target_reader.sv
module tb_digest_target_reader;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         hash_valid = 1'b0;
    logic [255:0] HASH = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_in = '0;
    logic         word_ready = 1'b0;

    logic         busy, result_valid, hit, word_valid, word_last;
    logic [31:0]  hit_nonce, word;
    logic [2:0]   word_index;
    logic [7:0]   drop_count;

    logic         busy0, rv0, hit0, wv0, wl0;
    logic [31:0]  hn0, w0;
    logic [2:0]   wi0;
    logic [7:0]   dc0;

    int tests = 0;
    int fails = 0;
    int exp_drop = 0;

    digest_target_reader #(.STREAM_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .hash_valid(hash_valid), .HASH(HASH),
        .target(target), .nonce_in(nonce_in), .busy(busy),
        .result_valid(result_valid), .hit(hit), .hit_nonce(hit_nonce),
        .word_valid(word_valid), .word_ready(word_ready), .word(word),
        .word_index(word_index), .word_last(word_last), .drop_count(drop_count)
    );

    digest_target_reader #(.STREAM_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .hash_valid(hash_valid), .HASH(HASH),
        .target(target), .nonce_in(nonce_in), .busy(busy0),
        .result_valid(rv0), .hit(hit0), .hit_nonce(hn0),
        .word_valid(wv0), .word_ready(word_ready), .word(w0),
        .word_index(wi0), .word_last(wl0), .drop_count(dc0)
    );

    always #5 clock = ~clock;

    // Issues one capture and waits for the decision. Optionally pulses
    // hash_valid (with a garbage HASH) for ndrop cycles during COMPARE.
    task automatic run_txn(input logic [255:0] h, input logic [255:0] t,
                           input logic [31:0] n, input int exp_lat,
                           input logic exp_hit, input logic [31:0] exp_nonce,
                           input int ndrop, input bit chk0, input string nm);
        int lat;
        HASH = h; target = t; nonce_in = n; hash_valid = 1'b1;
        @(posedge clock); #1;
        hash_valid = 1'b0;
        lat = 1;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL %s busy after capture: got %b want 1", nm, busy);
        end
        while (result_valid !== 1'b1 && lat < 20) begin
            hash_valid = (lat <= ndrop);
            HASH = ~h;
            @(posedge clock); #1;
            lat++;
        end
        hash_valid = 1'b0; HASH = h;
        exp_drop = exp_drop + ndrop;
        tests++;
        if (result_valid !== 1'b1 || lat != exp_lat) begin
            fails++; $display("FAIL %s latency: got %0d (rv=%b) want %0d", nm, lat, result_valid, exp_lat);
        end
        tests++;
        if (hit !== exp_hit || hit_nonce !== exp_nonce) begin
            fails++; $display("FAIL %s result: got hit=%b nonce=%h want hit=%b nonce=%h",
                              nm, hit, hit_nonce, exp_hit, exp_nonce);
        end
        tests++;
        if (drop_count !== exp_drop[7:0]) begin
            fails++; $display("FAIL %s drop_count: got %0d want %0d", nm, drop_count, exp_drop);
        end
        if (chk0) begin
            tests++;
            if (rv0 !== 1'b1 || busy0 !== 1'b0 || wv0 !== 1'b0 || hit0 !== exp_hit) begin
                fails++; $display("FAIL %s no-stream variant: got rv=%b busy=%b wv=%b hit=%b want 1 0 0 %b",
                                  nm, rv0, busy0, wv0, hit0, exp_hit);
            end
        end
        @(negedge clock); #0;
        @(posedge clock); #1;
    endtask

    // Called at the sample point of the result_valid cycle. bp selects the
    // 1,0,0,1 ready pattern; hv_last raises hash_valid on the final transfer.
    task automatic do_stream(input logic [255:0] h, input bit bp,
                             input bit hv_last, input string nm);
        logic [7:0][31:0] hw;
        int idx, cyc;
        bit rdy;
        hw = h; idx = 0; cyc = 0;
        while (idx < 8 && cyc < 100) begin
            rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            tests++;
            if (word_valid !== 1'b1 || word_index !== idx[2:0] || word !== hw[7-idx] ||
                word_last !== (idx == 7)) begin
                fails++; $display("FAIL %s beat %0d: got v=%b i=%0d w=%h l=%b want 1 %0d %h %b",
                                  nm, idx, word_valid, word_index, word, word_last, idx, hw[7-idx], idx == 7);
            end
            word_ready = rdy;
            if (hv_last && rdy && idx == 7) begin
                hash_valid = 1'b1;
                exp_drop++;
            end
            @(posedge clock); #1;
            hash_valid = 1'b0; word_ready = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        tests++;
        if (word_valid !== 1'b0 || busy !== 1'b0 || drop_count !== exp_drop[7:0]) begin
            fails++; $display("FAIL %s end: got v=%b busy=%b drops=%0d want 0 0 %0d",
                              nm, word_valid, busy, drop_count, exp_drop);
        end
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || hit !== 1'b0 || hit_nonce !== 32'd0 ||
            word_valid !== 1'b0 || word !== 32'd0 || word_index !== 3'd0 ||
            word_last !== 1'b0 || drop_count !== 8'd0) begin
            fails++; $display("FAIL %s: got busy=%b rv=%b hit=%b hn=%h v=%b w=%h i=%0d l=%b d=%0d want all 0",
                              nm, busy, result_valid, hit, hit_nonce, word_valid, word,
                              word_index, word_last, drop_count);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_state");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_early_backpressure();
        logic [255:0] h, t;
        h = {32'h0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        t = {32'h1, 224'h0};
        run_txn(h, t, 32'h12345678, 2, 1'b1, 32'h12345678, 0, 1'b1, "early");
    endtask

    task automatic test_equal();
        logic [255:0] h;
        h = {8{32'h11111111}};
        run_txn(h, h, 32'h0000AAAA, 9, 1'b0, 32'h12345678, 3, 1'b0, "equal");
        do_stream(h, 1'b0, 1'b1, "equal_stream");
        @(posedge clock); #1;
    endtask

    task automatic test_last_word();
        logic [255:0] h, t;
        h = {{7{32'hCAFE0000}}, 32'h5};
        t = {{7{32'hCAFE0000}}, 32'h6};
        run_txn(h, t, 32'h0BADF00D, 9, 1'b1, 32'h0BADF00D, 0, 1'b0, "last_word");
        do_stream(h, 1'b0, 1'b0, "last_word_stream");
        @(posedge clock); #1;
    endtask

    task automatic test_saturate();
        logic [255:0] h, t;
        h = {32'h00000010, 224'h0};
        t = {32'h00000020, 224'h0};
        run_txn(h, t, 32'h77777777, 2, 1'b1, 32'h77777777, 0, 1'b0, "sat_txn");
        hash_valid = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        hash_valid = 1'b0;
        exp_drop = 255;
        tests++;
        if (drop_count !== 8'd255 || word_valid !== 1'b1 || word_index !== 3'd0) begin
            fails++; $display("FAIL saturate: got drops=%0d v=%b i=%0d want 255 1 0",
                              drop_count, word_valid, word_index);
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] h, t;
        int c;
        c = 0;
        word_ready = 1'b1;
        while (word_index !== 3'd4 && c < 20) begin
            @(posedge clock); #1;
            c++;
        end
        tests++;
        if (word_index !== 3'd4) begin
            fails++; $display("FAIL mid_reset reach index 4: got %0d want 4", word_index);
        end
        word_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_zero("mid_reset_async");
        exp_drop = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        h = {32'h00000003, 32'hFFFFFFFF, 192'h0};
        t = {32'h00000003, 32'hFFFFFFFF, 32'h1, 160'h0};
        run_txn(h, t, 32'h5A5A5A5A, 4, 1'b1, 32'h5A5A5A5A, 0, 1'b0, "after_reset");
        do_stream(h, 1'b1, 1'b0, "after_reset_stream");
    endtask

    // Backpressure stream follows the early-decision result directly.
    task automatic test_back_to_back_bp();
        logic [255:0] h;
        h = {32'h0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        do_stream(h, 1'b1, 1'b0, "bp_stream");
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_early_backpressure();
        test_back_to_back_bp();
        test_equal();
        test_last_word();
        test_saturate();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
